alu_issuer: RTL and testbench
=============================

ALU_ISSUER -- requirements
Module: alu_issuer

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of completed-operation counter.
REQ-002 SHALL have port clk  input  1  single system clock, all state on rising edge.
REQ-003 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port req_valid  input  1  requester presents an operation.
REQ-005 SHALL have port req_ready  output  1  block can accept an operation.
REQ-006 SHALL have port req_op  input  3  ALU opcode (0 add, 1 sub, 2 and, 3 or, 4 srl, 5 sra).
REQ-007 SHALL have port req_a  input  32  operand A.
REQ-008 SHALL have port req_b  input  32  operand B.
REQ-009 SHALL have port alu_a  output  32  operand A driven to external combinational ALU.
REQ-010 SHALL have port alu_b  output  32  operand B driven to external ALU.
REQ-011 SHALL have port alu_op  output  3  opcode driven to external ALU.
REQ-012 SHALL have port alu_c  input  32  combinational result returned by external ALU.
REQ-013 SHALL have port res_valid  output  1  result available.
REQ-014 SHALL have port res_ready  input  1  consumer accepts result.
REQ-015 SHALL have port res_data  output  32  captured result.
REQ-016 SHALL have port res_err  output  1  result belongs to an illegal opcode (6 or 7).
REQ-017 SHALL have port op_cnt  output  CNT_W  count of completed result handshakes.

Function
REQ-018 SHALL implement a three-state FSM: IDLE, ISSUE, DONE.
REQ-019 SHALL drive req_ready=1 only in IDLE; res_valid=1 only in DONE.
REQ-020 SHALL, in IDLE with req_valid=1 at a rising edge, register req_a, req_b, req_op and move to ISSUE.
REQ-021 SHALL drive alu_a, alu_b, alu_op directly from the registered operands, holding them stable until the next accepted request.
REQ-022 SHALL, in ISSUE, at the next rising edge capture alu_c into res_data, set res_err=0 and move to DONE (result valid exactly one cycle after acceptance edge).
REQ-023 SHALL, in ISSUE with registered opcode 6 or 7, capture res_data=32'h0 and res_err=1 instead of alu_c (external ALU output undefined for these codes).
REQ-024 SHALL hold res_data and res_err stable in DONE while res_ready=0 (unbounded backpressure).
REQ-025 SHALL, in DONE with res_ready=1 at a rising edge, return to IDLE and increment op_cnt by 1 (illegal-opcode results included).
REQ-026 SHALL wrap op_cnt from 2^CNT_W-1 to 0 without flag.
REQ-027 SHALL ignore req_valid and all req_* inputs outside IDLE; no request queueing, no same-cycle DONE-to-accept bypass (max throughput one op per 3 cycles).
REQ-028 SHALL ignore res_ready outside DONE.
REQ-029 SHALL keep res_data/res_err holding last captured value in IDLE and ISSUE.
REQ-030 SHALL treat shift amounts as the external ALU does; block performs no arithmetic, passes all 32 operand bits unmodified.

Reset
REQ-031 SHALL, on reset_n=0, immediately (asynchronously) force state IDLE, req_ready=1 after release only, res_valid=0, res_data=0, res_err=0, op_cnt=0, alu_a=0, alu_b=0, alu_op=0.
REQ-032 SHALL, when reset asserts in ISSUE or DONE, abandon the in-flight operation: no result emitted, op_cnt not incremented.
REQ-033 SHALL leave req_ready=0 while reset_n=0 and resume accepting at the first rising edge after release.

Verification
REQ-034 SHALL verify add: req a=32'h7FFFFFFF, b=1, op=0 accepted edge k -> alu_op=0 after k, res_valid=1 after k+1, res_data=32'h80000000, res_err=0, op_cnt=1 after handshake.
REQ-035 SHALL verify sra vs srl: a=32'hF0000000, b=4, op=5 -> res_data=32'hFF000000; same with op=4 -> 32'h0F000000.
REQ-036 SHALL verify backpressure: res_ready=0 for 10 cycles after result of a=5,b=3,op=1 -> res_valid stays 1, res_data=2 stable, req_ready=0, new req_valid ignored; res_ready=1 -> IDLE, op_cnt increments once.
REQ-037 SHALL verify illegal opcode: op=7, alu_c forced 32'hDEADBEEF -> res_data=0, res_err=1, op_cnt increments on handshake.
REQ-038 SHALL verify reset mid-operation: reset_n low in DONE -> res_valid=0, op_cnt=0 asynchronously, no result handshake, next request after release processed normally.
REQ-039 SHALL verify counter wrap: CNT_W=2, five back-to-back completed operations -> op_cnt sequence 1,2,3,0,1.

Source files
------------

// File: rtl/alu_issuer_if.sv
// Handshake and external-ALU bundle for alu_issuer.
// Slave is the issuer; master is the requester/consumer/ALU side.
interface alu_issuer_if;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [2:0]  alu_op;
  logic [31:0] alu_c;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic        res_err;

  modport slave (
    input  req_valid, req_op, req_a, req_b,
    input  alu_c, res_ready,
    output req_ready, alu_a, alu_b, alu_op,
    output res_valid, res_data, res_err
  );

  modport master (
    output req_valid, req_op, req_a, req_b,
    output alu_c, res_ready,
    input  req_ready, alu_a, alu_b, alu_op,
    input  res_valid, res_data, res_err
  );
endinterface

// File: rtl/alu_issuer.sv
// Single-slot issuer: latches one request, samples an external
// combinational ALU one cycle later, holds the result until consumed.
module alu_issuer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  alu_issuer_if.slave      bus,
  output logic [CNT_W-1:0] op_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [31:0]      a_q, b_q;
  logic [2:0]       op_q;
  logic [31:0]      data_q;
  logic             err_q;
  logic [CNT_W-1:0] cnt_q;

  logic accept, capture, retire, illegal;

  assign accept  = (state_q == IDLE) && bus.req_valid;
  assign capture = (state_q == ISSUE);
  assign retire  = (state_q == DONE) && bus.res_ready;
  assign illegal = op_q[2] & op_q[1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.req_valid) state_d = ISSUE;
      ISSUE:   state_d = DONE;
      DONE:    if (bus.res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_q  <= '0;
      b_q  <= '0;
      op_q <= '0;
    end else if (accept) begin
      a_q  <= bus.req_a;
      b_q  <= bus.req_b;
      op_q <= bus.req_op;
    end
  end

  // ALU output is undefined for opcodes 6/7, so never sample it then
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q <= '0;
      err_q  <= 1'b0;
    end else if (capture) begin
      data_q <= illegal ? 32'h0 : bus.alu_c;
      err_q  <= illegal;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    cnt_q <= '0;
    else if (retire) cnt_q <= cnt_q + CNT_W'(1);
  end

  // Gate with reset so the requester never sees ready during reset
  assign bus.req_ready = (state_q == IDLE) && reset_n;
  assign bus.res_valid = (state_q == DONE);
  assign bus.res_data  = data_q;
  assign bus.res_err   = err_q;
  assign bus.alu_a     = a_q;
  assign bus.alu_b     = b_q;
  assign bus.alu_op    = op_q;
  assign op_cnt        = cnt_q;

endmodule

// File: tb/tb_alu_issuer.sv
// Directed self-checking bench for alu_issuer.
// A second instance with CNT_W=2 exercises counter wrap.
module tb_alu_issuer;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  alu_issuer_if i1 ();
  alu_issuer_if i2 ();
  logic [15:0] cnt1;
  logic [1:0]  cnt2;

  alu_issuer #(.CNT_W(16)) dut1 (
    .clk(clk), .reset_n(reset_n), .bus(i1), .op_cnt(cnt1)
  );
  alu_issuer #(.CNT_W(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .bus(i2), .op_cnt(cnt2)
  );

  function automatic logic [31:0] alu_f(
    input logic [2:0] op, input logic [31:0] a, input logic [31:0] b
  );
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a >> b[4:0];
      3'd5: return $unsigned($signed(a) >>> b[4:0]);
      default: return 32'hDEADBEEF;
    endcase
  endfunction

  assign i1.alu_c = alu_f(i1.alu_op, i1.alu_a, i1.alu_b);
  assign i2.alu_c = alu_f(i2.alu_op, i2.alu_a, i2.alu_b);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request to dut1 for a single edge, ending in ISSUE
  task automatic send1(
    input logic [2:0] op, input logic [31:0] a, input logic [31:0] b
  );
    i1.req_op = op;
    i1.req_a = a;
    i1.req_b = b;
    i1.req_valid = 1'b1;
    tick();
    i1.req_valid = 1'b0;
  endtask

  task automatic test_reset();
    i1.req_valid = 0; i1.req_op = 0; i1.req_a = 0; i1.req_b = 0;
    i1.res_ready = 0;
    i2.req_valid = 0; i2.req_op = 0; i2.req_a = 0; i2.req_b = 0;
    i2.res_ready = 0;
    reset_n = 1'b0;
    #12;
    checks++;
    if (i1.req_ready !== 1'b0) begin
      failures++;
      $display("FAIL rst_ready got %b exp 0", i1.req_ready);
    end
    checks++;
    if (i1.res_valid !== 1'b0 || cnt1 !== 16'd0) begin
      failures++;
      $display("FAIL rst_out got v=%b cnt=%0d exp 0/0",
               i1.res_valid, cnt1);
    end
    checks++;
    if (i1.alu_a !== 0 || i1.alu_b !== 0 || i1.alu_op !== 0
        || i1.res_data !== 0 || i1.res_err !== 0) begin
      failures++;
      $display("FAIL rst_data got a=%h b=%h op=%0d d=%h e=%b exp 0",
               i1.alu_a, i1.alu_b, i1.alu_op, i1.res_data, i1.res_err);
    end
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    checks++;
    if (i1.req_ready !== 1'b1) begin
      failures++;
      $display("FAIL rel_ready got %b exp 1", i1.req_ready);
    end
  endtask

  task automatic test_add();
    tick();
    send1(3'd0, 32'h7FFFFFFF, 32'h1);
    checks++;
    if (i1.alu_op !== 3'd0 || i1.alu_a !== 32'h7FFFFFFF
        || i1.alu_b !== 32'h1) begin
      failures++;
      $display("FAIL add_issue got op=%0d a=%h b=%h exp 0/7fffffff/1",
               i1.alu_op, i1.alu_a, i1.alu_b);
    end
    checks++;
    if (i1.res_valid !== 1'b0 || i1.req_ready !== 1'b0) begin
      failures++;
      $display("FAIL add_issue_hs got v=%b r=%b exp 0/0",
               i1.res_valid, i1.req_ready);
    end
    tick();
    checks++;
    if (i1.res_valid !== 1'b1 || i1.res_data !== 32'h80000000
        || i1.res_err !== 1'b0) begin
      failures++;
      $display("FAIL add_res got v=%b d=%h e=%b exp 1/80000000/0",
               i1.res_valid, i1.res_data, i1.res_err);
    end
    i1.res_ready = 1'b1;
    tick();
    i1.res_ready = 1'b0;
    checks++;
    if (i1.res_valid !== 1'b0 || cnt1 !== 16'd1
        || i1.req_ready !== 1'b1) begin
      failures++;
      $display("FAIL add_hs got v=%b cnt=%0d r=%b exp 0/1/1",
               i1.res_valid, cnt1, i1.req_ready);
    end
  endtask

  task automatic test_shift();
    send1(3'd5, 32'hF0000000, 32'd4);
    tick();
    checks++;
    if (i1.res_data !== 32'hFF000000) begin
      failures++;
      $display("FAIL sra got %h exp ff000000", i1.res_data);
    end
    i1.res_ready = 1'b1;
    tick();
    i1.res_ready = 1'b0;
    send1(3'd4, 32'hF0000000, 32'd4);
    checks++;
    if (i1.res_data !== 32'hFF000000) begin
      failures++;
      $display("FAIL hold_issue got %h exp ff000000", i1.res_data);
    end
    tick();
    checks++;
    if (i1.res_data !== 32'h0F000000 || i1.res_valid !== 1'b1) begin
      failures++;
      $display("FAIL srl got %h v=%b exp 0f000000/1",
               i1.res_data, i1.res_valid);
    end
    i1.res_ready = 1'b1;
    tick();
    i1.res_ready = 1'b0;
    checks++;
    if (cnt1 !== 16'd3) begin
      failures++;
      $display("FAIL shift_cnt got %0d exp 3", cnt1);
    end
  endtask

  task automatic test_backpressure();
    send1(3'd1, 32'd5, 32'd3);
    tick();
    for (int i = 0; i < 10; i++) begin
      i1.req_valid = 1'b1;
      i1.req_op = 3'd0;
      i1.req_a = 32'h100 + i;
      checks++;
      if (i1.res_valid !== 1'b1 || i1.res_data !== 32'd2
          || i1.req_ready !== 1'b0 || i1.alu_a !== 32'd5) begin
        failures++;
        $display("FAIL bp_%0d got v=%b d=%h r=%b a=%h exp 1/2/0/5",
                 i, i1.res_valid, i1.res_data, i1.req_ready, i1.alu_a);
      end
      tick();
    end
    i1.req_valid = 1'b0;
    i1.res_ready = 1'b1;
    tick();
    checks++;
    if (i1.res_valid !== 1'b0 || cnt1 !== 16'd4) begin
      failures++;
      $display("FAIL bp_release got v=%b cnt=%0d exp 0/4",
               i1.res_valid, cnt1);
    end
    tick();
    checks++;
    if (cnt1 !== 16'd4 || i1.req_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_idle got cnt=%0d r=%b exp 4/1",
               cnt1, i1.req_ready);
    end
    i1.res_ready = 1'b0;
  endtask

  task automatic test_illegal();
    send1(3'd7, 32'h12345678, 32'h9);
    checks++;
    if (i1.alu_c !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL ill_alu got %h exp deadbeef", i1.alu_c);
    end
    tick();
    checks++;
    if (i1.res_data !== 32'h0 || i1.res_err !== 1'b1
        || i1.res_valid !== 1'b1) begin
      failures++;
      $display("FAIL ill_res got d=%h e=%b v=%b exp 0/1/1",
               i1.res_data, i1.res_err, i1.res_valid);
    end
    i1.res_ready = 1'b1;
    tick();
    i1.res_ready = 1'b0;
    checks++;
    if (cnt1 !== 16'd5 || i1.res_err !== 1'b1) begin
      failures++;
      $display("FAIL ill_hs got cnt=%0d e=%b exp 5/1", cnt1, i1.res_err);
    end
  endtask

  task automatic test_reset_mid();
    send1(3'd2, 32'hFF00FF00, 32'h0FF00FF0);
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (i1.res_valid !== 1'b0 || cnt1 !== 16'd0
        || i1.req_ready !== 1'b0 || i1.res_data !== 32'h0) begin
      failures++;
      $display("FAIL mid_rst got v=%b cnt=%0d r=%b d=%h exp 0/0/0/0",
               i1.res_valid, cnt1, i1.req_ready, i1.res_data);
    end
    i1.res_ready = 1'b1;
    tick();
    @(negedge clk);
    reset_n = 1'b1;
    i1.res_ready = 1'b0;
    tick();
    checks++;
    if (cnt1 !== 16'd0 || i1.req_ready !== 1'b1) begin
      failures++;
      $display("FAIL mid_rel got cnt=%0d r=%b exp 0/1",
               cnt1, i1.req_ready);
    end
    send1(3'd3, 32'hF0, 32'h0F);
    tick();
    checks++;
    if (i1.res_data !== 32'hFF || i1.res_valid !== 1'b1) begin
      failures++;
      $display("FAIL mid_next got d=%h v=%b exp ff/1",
               i1.res_data, i1.res_valid);
    end
    i1.res_ready = 1'b1;
    tick();
    i1.res_ready = 1'b0;
    checks++;
    if (cnt1 !== 16'd1) begin
      failures++;
      $display("FAIL mid_cnt got %0d exp 1", cnt1);
    end
  endtask

  task automatic test_wrap();
    logic [1:0] exp_seq [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    i2.res_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      i2.req_op = 3'd0;
      i2.req_a = i;
      i2.req_b = 32'd10;
      i2.req_valid = 1'b1;
      tick();
      i2.req_valid = 1'b0;
      tick();
      checks++;
      if (i2.res_data !== 32'(i + 10)) begin
        failures++;
        $display("FAIL wrap_data_%0d got %h exp %h",
                 i, i2.res_data, 32'(i + 10));
      end
      tick();
      checks++;
      if (cnt2 !== exp_seq[i]) begin
        failures++;
        $display("FAIL wrap_cnt_%0d got %0d exp %0d",
                 i, cnt2, exp_seq[i]);
      end
    end
    i2.res_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_add();
    test_shift();
    test_backpressure();
    test_illegal();
    test_reset_mid();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
